// File: rtl/banked_dual_port_sram.sv
// Two-port scratchpad built from NUM_BANKS single-port SRAM banks, round-robin on bank conflicts.
// Define SRAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module banked_dual_port_sram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned BANK_DEPTH = 32768,
  parameter int unsigned NUM_BANKS  = 6,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [OUT_W-1:0]  a_rsp_rdata,
  output logic              a_rsp_err,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [OUT_W-1:0]  b_rsp_rdata,
  output logic              b_rsp_err,
  output logic              err_sticky
);

  localparam int unsigned BANK_AW    = $clog2(BANK_DEPTH);
  localparam int unsigned BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned FIELD_W    = BANK_AW + BANK_SEL_W;
  localparam logic [BANK_SEL_W:0] NumBanksW = (BANK_SEL_W + 1)'(NUM_BANKS);

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            req_valid, req_we, req_ready, acc, oor;
  logic [ADDR_W-1:0]     req_addr  [2];
  logic [DATA_W-1:0]     req_wdata [2];
  logic [BANK_SEL_W-1:0] req_bank  [2];
  logic [BANK_AW-1:0]    req_word  [2];

  assign req_valid    = {b_req_valid, a_req_valid};
  assign req_we       = {b_req_we, a_req_we};
  assign req_addr[0]  = a_req_addr;
  assign req_addr[1]  = b_req_addr;
  assign req_wdata[0] = a_req_wdata;
  assign req_wdata[1] = b_req_wdata;

  always_comb begin
    oor = '0;
    for (int p = 0; p < 2; p++) begin
      req_bank[p] = req_addr[p][FIELD_W-1:BANK_AW];
      req_word[p] = req_addr[p][BANK_AW-1:0];
      oor[p]      = ({1'b0, req_bank[p]} >= NumBanksW) || ((req_addr[p] >> FIELD_W) != '0);
    end
  end

  // Out-of-range requests never reach a bank, so they never conflict.
  logic conflict, rr_q, rr_d;
  assign conflict     = (&req_valid) && !(|oor) && (req_bank[0] == req_bank[1]);
  assign req_ready[0] = !rst && (!conflict || !rr_q);
  assign req_ready[1] = !rst && (!conflict || rr_q);
  assign acc          = req_valid & req_ready;
  assign rr_d         = conflict ? !rr_q : rr_q;

  assign a_req_ready = req_ready[0];
  assign b_req_ready = req_ready[1];

  logic [NUM_BANKS-1:0] bank_cs, bank_oe, bank_web;
  logic [BANK_AW-1:0]   bank_a  [NUM_BANKS];
  logic [DATA_W-1:0]    bank_di [NUM_BANKS];
  logic [DATA_W-1:0]    bank_do [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_cs[b]  = 1'b0;
      bank_oe[b]  = 1'b0;
      bank_web[b] = 1'b1;
      bank_a[b]   = '0;
      bank_di[b]  = '0;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] && !oor[p] && (req_bank[p] == BANK_SEL_W'(b))) begin
          bank_cs[b]  = 1'b1;
          bank_oe[b]  = !req_we[p];
          bank_web[b] = !req_we[p];
          bank_a[b]   = req_word[p];
          bank_di[b]  = req_wdata[p];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];
    logic [DATA_W-1:0] do_q;
    always_ff @(posedge clk) begin
      if (bank_cs[g]) begin
        if (!bank_web[g]) begin
          mem[bank_a[g]] <= bank_di[g];
        end else if (bank_oe[g]) begin
          do_q <= mem[bank_a[g]];
        end
      end
    end
    assign bank_do[g] = do_q;
  end

  logic [1:0]            rsp1_valid_q, rsp1_err_q;
  logic [BANK_SEL_W-1:0] rsp1_bank_q [2];
  logic                  err_sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q           <= 1'b0;
      err_sticky_q   <= 1'b0;
      rsp1_valid_q   <= '0;
      rsp1_err_q     <= '0;
      rsp1_bank_q[0] <= '0;
      rsp1_bank_q[1] <= '0;
    end else begin
      rr_q         <= rr_d;
      rsp1_valid_q <= acc & ~req_we;
      rsp1_err_q   <= acc & ~req_we & oor;
      if (|(acc & oor)) err_sticky_q <= 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] && !req_we[p] && !oor[p]) rsp1_bank_q[p] <= req_bank[p];
      end
    end
  end

  // Mux keyed by the latched bank so a new request cannot disturb a pending response.
  logic [OUT_W-1:0] rsp1_rdata [2];
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rsp1_rdata[p] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rsp1_valid_q[p] && !rsp1_err_q[p] && (rsp1_bank_q[p] == BANK_SEL_W'(b))) begin
          rsp1_rdata[p] = OUT_W'($signed(bank_do[b]));
        end
      end
    end
  end

  logic [1:0]       rsp_valid, rsp_err;
  logic [OUT_W-1:0] rsp_rdata [2];

`ifdef SRAM_OUT_REG_EN
  logic [1:0]       rsp2_valid_q, rsp2_err_q;
  logic [OUT_W-1:0] rsp2_rdata_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp2_valid_q    <= '0;
      rsp2_err_q      <= '0;
      rsp2_rdata_q[0] <= '0;
      rsp2_rdata_q[1] <= '0;
    end else begin
      rsp2_valid_q    <= rsp1_valid_q;
      rsp2_err_q      <= rsp1_err_q;
      rsp2_rdata_q[0] <= rsp1_rdata[0];
      rsp2_rdata_q[1] <= rsp1_rdata[1];
    end
  end

  assign rsp_valid = rsp2_valid_q;
  assign rsp_err   = rsp2_err_q;
  assign rsp_rdata = rsp2_rdata_q;
`else
  assign rsp_valid = rsp1_valid_q;
  assign rsp_err   = rsp1_err_q;
  assign rsp_rdata = rsp1_rdata;
`endif

  // Responses in flight when reset rises are hidden immediately, not one cycle later.
  assign a_rsp_valid = rsp_valid[0] && !rst;
  assign a_rsp_err   = rsp_err[0] && !rst;
  assign a_rsp_rdata = rst ? '0 : rsp_rdata[0];
  assign b_rsp_valid = rsp_valid[1] && !rst;
  assign b_rsp_err   = rsp_err[1] && !rst;
  assign b_rsp_rdata = rst ? '0 : rsp_rdata[1];
  assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_banked_dual_port_sram.sv
// Randomized scoreboard bench for banked_dual_port_sram with a word-addressed memory model.
module tb_banked_dual_port_sram;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OUT_W      = 32;
  localparam int unsigned BANK_DEPTH = 32768;
  localparam int unsigned NUM_BANKS  = 6;
  localparam int unsigned ADDR_W     = 32;
  localparam logic [31:0] LIMIT      = 32'(NUM_BANKS * BANK_DEPTH);
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
  logic [ADDR_W-1:0] a_req_addr = '0;
  logic [DATA_W-1:0] a_req_wdata = '0;
  logic              a_rsp_valid, a_rsp_err;
  logic [OUT_W-1:0]  a_rsp_rdata;
  logic              b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [ADDR_W-1:0] b_req_addr = '0;
  logic [DATA_W-1:0] b_req_wdata = '0;
  logic              b_rsp_valid, b_rsp_err;
  logic [OUT_W-1:0]  b_rsp_rdata;
  logic              err_sticky;

  banked_dual_port_sram #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .BANK_DEPTH(BANK_DEPTH), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q [2][$];
  logic [15:0] mem [int unsigned];
  logic        rr_m = 1'b0;
  logic        sticky_m = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] addr);
    exp_t e;
    logic [15:0] d;
    e.due = cyc + LAT;
    if (addr >= LIMIT) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      d      = mem[addr];
      e.data = {{16{d[15]}}, d};
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // Present one cycle of requests and apply the reference rules to predict the outcome.
  task automatic drive(input logic av, input logic awe, input logic [31:0] aad, input logic [15:0] awd,
                       input logic bv, input logic bwe, input logic [31:0] bad, input logic [15:0] bwd);
    logic ao, bo, conf, ra, rb;
    @(negedge clk);
    a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = bad; b_req_wdata = bwd;
    #1;
    ao   = (aad >= LIMIT);
    bo   = (bad >= LIMIT);
    conf = av && bv && !ao && !bo && ((aad / BANK_DEPTH) == (bad / BANK_DEPTH));
    ra   = !rst && (!conf || !rr_m);
    rb   = !rst && (!conf || rr_m);
    if (av) check("a_req_ready", {31'd0, a_req_ready}, {31'd0, ra});
    if (bv) check("b_req_ready", {31'd0, b_req_ready}, {31'd0, rb});
    if (av && ra && !awe) q[0].push_back(mk_exp(aad));
    if (bv && rb && !bwe) q[1].push_back(mk_exp(bad));
    if (av && ra && awe && !ao) mem[aad] = awd;
    if (bv && rb && bwe && !bo) mem[bad] = bwd;
    if ((av && ra && ao) || (bv && rb && bo)) sticky_m = 1'b1;
    if (conf && !rst) rr_m = !rr_m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 32'd0, 16'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst a_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    check("rst a_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    check("rst b_rsp_err", {31'd0, b_rsp_err}, 32'd0);
    check("rst b_rsp_rdata", b_rsp_rdata, 32'd0);
    check("rst err_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst a_req_ready", {31'd0, a_req_ready}, 32'd0);
    check("rst b_req_ready", {31'd0, b_req_ready}, 32'd0);
  endtask

  task automatic mon_port(input int p, input logic v, input logic [31:0] d, input logic e);
    exp_t x;
    if (v) begin
      if (q[p].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected port %0d: got data %h, expected no response", p, d);
      end else begin
        x = q[p].pop_front();
        check($sformatf("rsp_rdata port %0d", p), d, x.data);
        check($sformatf("rsp_err port %0d", p), {31'd0, e}, {31'd0, x.err});
        check($sformatf("rsp_cycle port %0d", p), cyc, x.due);
      end
    end else if (q[p].size() != 0 && q[p][0].due <= cyc) begin
      x = q[p].pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL rsp_missing port %0d: got no response, expected data %h at cycle %0d", p, x.data,
               x.due);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      mon_port(0, a_rsp_valid, a_rsp_rdata, a_rsp_err);
      mon_port(1, b_rsp_valid, b_rsp_rdata, b_rsp_err);
      check("err_sticky", {31'd0, err_sticky}, {31'd0, sticky_m});
    end
  end

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    if (r == 0)      a = LIMIT + 32'($urandom_range(0, 2 * BANK_DEPTH - 1));
    else if (r == 1) a = 32'h8000_0000 | 32'($urandom_range(0, 1023));
    else a = 32'($urandom_range(0, NUM_BANKS - 1) * BANK_DEPTH + $urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    for (int b = 0; b < int'(NUM_BANKS); b++)
      for (int w = 0; w < 8; w++)
        drive(1'b1, 1'b1, 32'(b * BANK_DEPTH + w), 16'($urandom), 1'b0, 1'b0, 32'd0, 16'd0);

    drive(1'b1, 1'b1, 32'h10, 16'h8001, 1'b0, 1'b0, 32'd0, 16'd0);
    drive(1'b1, 1'b0, 32'h10, 16'd0, 1'b0, 1'b0, 32'd0, 16'd0);
    repeat (LAT) idle();
    check("plan1 a_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    check("plan1 a_rsp_rdata", a_rsp_rdata, 32'hFFFF_8001);
    check("plan1 a_rsp_err", {31'd0, a_rsp_err}, 32'd0);

    drive(1'b1, 1'b0, 32'd5, 16'd0, 1'b1, 1'b1, 32'(3 * BANK_DEPTH + 5), 16'h1234);
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 32'(3 * BANK_DEPTH + 5), 16'd0);
    repeat (LAT) idle();
    check("plan2 b_rsp_rdata", b_rsp_rdata, 32'h0000_1234);

    drive(1'b1, 1'b0, LIMIT, 16'd0, 1'b0, 1'b0, 32'd0, 16'd0);
    repeat (LAT) idle();
    check("oor a_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    check("oor a_rsp_rdata", a_rsp_rdata, 32'd0);
    check("oor a_rsp_err", {31'd0, a_rsp_err}, 32'd1);
    check("oor err_sticky", {31'd0, err_sticky}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b1, 32'h7FFF_FFFF, 16'hBEEF);
    idle();
    idle();
    check("oor write err_sticky", {31'd0, err_sticky}, 32'd1);

    // Read, then raise reset just after its acceptance edge: the response must never appear.
    drive(1'b1, 1'b0, 32'(BANK_DEPTH + 1), 16'd0, 1'b0, 1'b0, 32'd0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q[0].delete();
    q[1].delete();
    @(negedge clk);
    sticky_m = 1'b0;
    rr_m = 1'b0;
    drive(1'b1, 1'b1, 32'd3, 16'hDEAD, 1'b0, 1'b0, 32'd0, 16'd0);
    idle();
    check_reset_outputs();
    rst = 1'b0;

    // Same-bank conflict straight out of reset: grants go A, B, A, B.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(2 * BANK_DEPTH + 1), 16'd0, 1'b1, 1'b0, 32'(2 * BANK_DEPTH + 2), 16'd0);
      check($sformatf("grant a %0d", i), {31'd0, a_req_ready}, {31'd0, (i % 2 == 0)});
      check($sformatf("grant b %0d", i), {31'd0, b_req_ready}, {31'd0, (i % 2 == 1)});
    end
    drive(1'b1, 1'b0, 32'd3, 16'd0, 1'b0, 1'b0, 32'd0, 16'd0);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(), 16'($urandom));
    end

    repeat (LAT + 3) idle();
    check("drain port a", q[0].size(), 32'd0);
    check("drain port b", q[1].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
